// File: rtl/fifo_rd_pingpong.sv
// Read-side drain stage for an async FIFO. It pops words into a two-entry ping-pong buffer and presents them as a valid/ready stream.
// Optional statistics counters are enabled by defining RD_STAT_EN.
module fifo_rd_pingpong #(
  parameter int DSIZE  = 8,
  parameter int RD_LAT = 0,
  parameter int CNT_W  = 16
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic             rempty,
  output logic             r_req,
  input  logic [DSIZE-1:0] rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic [1:0]       occ
`ifdef RD_STAT_EN
  ,
  output logic [CNT_W-1:0] stat_words,
  output logic [CNT_W-1:0] stat_stall
`endif
);

  logic             pop;
  logic             deq;
  logic             cap;
  logic             inflight;
  logic             wsel;
  logic             rsel;
  logic [DSIZE-1:0] bank0;
  logic [DSIZE-1:0] bank1;
  logic [2:0]       load;
  logic [2:0]       occ_sum;

  if ((RD_LAT != 0 && RD_LAT != 1) || CNT_W < 1) begin : g_bad_param
    $error("fifo_rd_pingpong: RD_LAT must be 0 or 1 and CNT_W positive");
  end

  assign out_valid = (occ != 2'd0);
  assign deq       = out_valid & out_ready;

  // Slots committed after this cycle: buffered plus in flight, minus the word leaving now.
  assign load  = {1'b0, occ} + {2'b00, inflight} - {2'b00, deq};
  assign r_req = ~rrst & ~rempty & (load < 3'd2);
  assign pop   = r_req & ~rempty;

  if (RD_LAT == 0) begin : g_lat0
    assign cap      = pop;
    assign inflight = 1'b0;
  end else begin : g_lat1
    logic inflight_p1;

    // Stage p1: the FIFO memory registers rdata one cycle after the pop.
    always_ff @(posedge rclk) begin
      if (rrst) inflight_p1 <= 1'b0;
      else      inflight_p1 <= pop;
    end

    assign cap      = inflight_p1;
    assign inflight = inflight_p1;
  end

  assign occ_sum  = {1'b0, occ} + {2'b00, cap} - {2'b00, deq};
  assign out_data = rsel ? bank1 : bank0;

  // Buffer stage: capture into bank[wsel], drain from bank[rsel].
  always_ff @(posedge rclk) begin
    if (rrst) begin
      occ   <= 2'd0;
      wsel  <= 1'b0;
      rsel  <= 1'b0;
      bank0 <= '0;
      bank1 <= '0;
    end else begin
      assert (occ_sum <= 3'd2);
      occ <= occ_sum[1:0];
      if (cap) begin
        wsel <= ~wsel;
        if (wsel) bank1 <= rdata;
        else      bank0 <= rdata;
      end
      if (deq) rsel <= ~rsel;
    end
  end

`ifdef RD_STAT_EN
  always_ff @(posedge rclk) begin
    if (rrst) begin
      stat_words <= '0;
      stat_stall <= '0;
    end else begin
      if (deq)                    stat_words <= stat_words + CNT_W'(1);
      if (out_valid & ~out_ready) stat_stall <= stat_stall + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_pingpong.sv
// Directed bench for fifo_rd_pingpong: one instance with RD_LAT=0 (u0) and one with RD_LAT=1 (u1), each fed by a small FIFO model.
module tb_fifo_rd_pingpong;

  logic       rclk;
  logic       rrst;
  logic       r_req0, r_req1;
  logic       rempty0, rempty1;
  logic [7:0] rdata0, rdata1;
  logic       out_valid0, out_valid1;
  logic       out_ready0, out_ready1;
  logic [7:0] out_data0, out_data1;
  logic [1:0] occ0, occ1;
`ifdef RD_STAT_EN
  logic [15:0] sw0, ss0, sw1, ss1;
`endif

  logic [7:0] mem0 [0:15];
  logic [7:0] mem1 [0:15];
  logic [3:0] rptr0, wptr0, rptr1, wptr1;

  int n_chk;
  int n_err;

  fifo_rd_pingpong #(.DSIZE(8), .RD_LAT(0), .CNT_W(16)) u0 (
    .rclk(rclk), .rrst(rrst), .rempty(rempty0), .r_req(r_req0), .rdata(rdata0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0), .occ(occ0)
`ifdef RD_STAT_EN
    , .stat_words(sw0), .stat_stall(ss0)
`endif
  );

  fifo_rd_pingpong #(.DSIZE(8), .RD_LAT(1), .CNT_W(16)) u1 (
    .rclk(rclk), .rrst(rrst), .rempty(rempty1), .r_req(r_req1), .rdata(rdata1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .occ(occ1)
`ifdef RD_STAT_EN
    , .stat_words(sw1), .stat_stall(ss1)
`endif
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  // FIFO models: u0 memory is combinational from the read pointer, u1 memory is registered.
  assign rempty0 = (rptr0 == wptr0);
  assign rempty1 = (rptr1 == wptr1);
  assign rdata0  = mem0[rptr0];

  always @(posedge rclk) begin
    if (r_req0 && !rempty0) rptr0 <= rptr0 + 4'd1;
    if (r_req1 && !rempty1) begin
      rptr1  <= rptr1 + 4'd1;
      rdata1 <= mem1[rptr1];
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  logic [7:0] exp_a [0:3];
  logic [7:0] exp_b [0:4];

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_a[0] = 8'h11; exp_a[1] = 8'h22; exp_a[2] = 8'h33; exp_a[3] = 8'h44;
    exp_b[0] = 8'hA1; exp_b[1] = 8'hA2; exp_b[2] = 8'hA3; exp_b[3] = 8'hA4; exp_b[4] = 8'hA5;
    for (int i = 0; i < 16; i++) begin
      mem0[i] = 8'h00;
      mem1[i] = 8'h00;
    end
    for (int i = 0; i < 4; i++) begin
      mem0[i] = exp_a[i];
      mem1[i] = exp_a[i];
    end
    for (int i = 0; i < 5; i++) begin
      mem0[4+i] = exp_b[i];
      mem1[4+i] = 8'hB1 + 8'(i);
    end
    rptr0 = 4'd0; wptr0 = 4'd4;
    rptr1 = 4'd0; wptr1 = 4'd0;
    rdata1 = 8'h00;
    out_ready0 = 1'b1;
    out_ready1 = 1'b0;
    rrst = 1'b1;

    // Reset held three cycles with data available
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_r_req", 32'(r_req0), 32'd0);
      check("rst_valid", 32'(out_valid0), 32'd0);
      check("rst_occ", 32'(occ0), 32'd0);
    end
    check("rst_data", 32'(out_data0), 32'd0);
    check("rst_no_pop", 32'(rptr0), 32'd0);
    rrst = 1'b0;
    #1;
    check("first_r_req", 32'(r_req0), 32'd1);

    // Streaming RD_LAT=0
    for (int k = 0; k < 4; k++) begin
      tick();
      check("l0_valid", 32'(out_valid0), 32'd1);
      check("l0_data", 32'(out_data0), 32'(exp_a[k]));
    end
    check("l0_empty_r_req", 32'(r_req0), 32'd0);
    tick();
    check("l0_drained_valid", 32'(out_valid0), 32'd0);
    check("l0_drained_occ", 32'(occ0), 32'd0);

    // Backpressure with five words available
    wptr0 = 4'd9;
    out_ready0 = 1'b0;
    #1;
    check("bp_r_req_start", 32'(r_req0), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("bp_occ", 32'(occ0), 32'd2);
    check("bp_r_req", 32'(r_req0), 32'd0);
    check("bp_pops", 32'(rptr0), 32'd6);
    check("bp_hold_data", 32'(out_data0), 32'hA1);
    out_ready0 = 1'b1;
    #1;
    check("full_deq_r_req", 32'(r_req0), 32'd1);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", 32'(out_valid0), 32'd1);
      check("bp_data", 32'(out_data0), 32'(exp_b[k]));
      tick();
      if (k < 3) check("bp_occ_full_deq", 32'(occ0), 32'd2);
    end
    check("bp_end_occ", 32'(occ0), 32'd0);
    check("bp_end_valid", 32'(out_valid0), 32'd0);
`ifdef RD_STAT_EN
    check("stat_words", 32'(sw0), 32'd9);
    check("stat_stall", 32'(ss0), 32'd3);
`endif

    // Streaming RD_LAT=1
    wptr1 = 4'd4;
    out_ready1 = 1'b1;
    #1;
    check("l1_r_req", 32'(r_req1), 32'd1);
    tick();
    check("l1_not_yet_valid", 32'(out_valid1), 32'd0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("l1_valid", 32'(out_valid1), 32'd1);
      check("l1_data", 32'(out_data1), 32'(exp_a[k]));
      check("l1_occ_max", 32'(occ1 <= 2'd2), 32'd1);
    end
    tick();
    check("l1_drained_valid", 32'(out_valid1), 32'd0);
    check("l1_drained_occ", 32'(occ1), 32'd0);

    // Reset with one word buffered and one in flight
    wptr1 = 4'd9;
    out_ready1 = 1'b0;
    tick();
    tick();
    check("mid_occ", 32'(occ1), 32'd1);
    check("mid_r_req_limit", 32'(r_req1), 32'd0);
    rrst = 1'b1;
    tick();
    check("mid_rst_occ", 32'(occ1), 32'd0);
    check("mid_rst_valid", 32'(out_valid1), 32'd0);
`ifdef RD_STAT_EN
    check("mid_rst_words", 32'(sw0), 32'd0);
    check("mid_rst_stall", 32'(ss0), 32'd0);
`endif
    rrst = 1'b0;
    out_ready1 = 1'b1;
    #1;
    check("post_rst_r_req", 32'(r_req1), 32'd1);
    tick();
    check("inflight_dropped", 32'(out_valid1), 32'd0);
    tick();
    check("post_rst_valid", 32'(out_valid1), 32'd1);
    check("post_rst_data", 32'(out_data1), 32'hB3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
